// File: rtl/sar_adc_if.sv
// sar_adc_if: signal bundle between the SAR controller and its environment.
//   start_i    - conversion request (environment -> controller)
//   cmp_i      - comparator decision (comparator netlist -> controller)
//   sample_o   - track/hold control, 1 = track
//   dac_code_o - trial code driven to the DAC
//   busy_o     - conversion in progress
//   data_o     - last completed result
//   valid_o    - one-cycle pulse when data_o updates
// The controller connects through the slave modport; the requester/comparator
// side (or a bench) uses the master modport.
interface sar_adc_if #(
    parameter int WIDTH = 10
);
    logic             start_i;
    logic             cmp_i;
    logic             sample_o;
    logic [WIDTH-1:0] dac_code_o;
    logic             busy_o;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;

    modport slave (
        input  start_i,
        input  cmp_i,
        output sample_o,
        output dac_code_o,
        output busy_o,
        output data_o,
        output valid_o
    );

    modport master (
        output start_i,
        output cmp_i,
        input  sample_o,
        input  dac_code_o,
        input  busy_o,
        input  data_o,
        input  valid_o
    );
endinterface

// File: rtl/sar_adc.sv
// sar_adc_ctrl: successive-approximation ADC controller.
// Tracks the input for ACQ_CYCLES, then binary-searches the code MSB first,
// holding each trial DAC code for SETTLE_CYCLES and sampling the comparator
// only at the edge that ends the last settle cycle of each bit.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; aborts any conversion in flight
//   bus   - sar_adc_if.slave (start_i, cmp_i in; sample_o, dac_code_o,
//           busy_o, data_o, valid_o out), all outputs registered
module sar_adc_ctrl #(
    parameter int WIDTH         = 10,
    parameter int ACQ_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    sar_adc_if.slave bus
);
    localparam int ACQ_W    = $clog2(ACQ_CYCLES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int IDX_W    = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACQUIRE, CONVERT} state_t;

    state_t              state,      state_nxt;
    logic [ACQ_W-1:0]    acq_cnt,    acq_cnt_nxt;
    logic [SETTLE_W-1:0] settle_cnt, settle_cnt_nxt;
    logic [IDX_W-1:0]    bit_idx,    bit_idx_nxt;
    logic [WIDTH-1:0]    trial,      trial_nxt;
    logic                sample,     sample_nxt;
    logic [WIDTH-1:0]    dac_code,   dac_code_nxt;
    logic                busy,       busy_nxt;
    logic [WIDTH-1:0]    data,       data_nxt;
    logic                valid,      valid_nxt;
    logic [WIDTH-1:0]    code;
    logic [IDX_W-1:0]    idx_m1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acq_cnt    <= '0;
            settle_cnt <= '0;
            bit_idx    <= '0;
            trial      <= '0;
            sample     <= 1'b0;
            dac_code   <= '0;
            busy       <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
        end else begin
            state      <= state_nxt;
            acq_cnt    <= acq_cnt_nxt;
            settle_cnt <= settle_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            trial      <= trial_nxt;
            sample     <= sample_nxt;
            dac_code   <= dac_code_nxt;
            busy       <= busy_nxt;
            data       <= data_nxt;
            valid      <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        acq_cnt_nxt    = acq_cnt;
        settle_cnt_nxt = settle_cnt;
        bit_idx_nxt    = bit_idx;
        trial_nxt      = trial;
        sample_nxt     = sample;
        dac_code_nxt   = dac_code;
        busy_nxt       = busy;
        data_nxt       = data;
        valid_nxt      = 1'b0;
        idx_m1         = bit_idx - 1'b1;
        // Current trial with the bit under test resolved by the comparator.
        code           = trial;
        if (!bus.cmp_i) begin
            code[bit_idx] = 1'b0;
        end

        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    state_nxt   = ACQUIRE;
                    sample_nxt  = 1'b1;
                    busy_nxt    = 1'b1;
                    acq_cnt_nxt = ACQ_W'(ACQ_CYCLES - 1);
                end
            end
            ACQUIRE: begin
                if (acq_cnt == '0) begin
                    state_nxt      = CONVERT;
                    sample_nxt     = 1'b0;
                    bit_idx_nxt    = IDX_W'(WIDTH - 1);
                    trial_nxt      = MSB_ONE;
                    dac_code_nxt   = MSB_ONE;
                    settle_cnt_nxt = SETTLE_W'(SETTLE_CYCLES - 1);
                end else begin
                    acq_cnt_nxt = acq_cnt - 1'b1;
                end
            end
            CONVERT: begin
                if (settle_cnt != '0) begin
                    settle_cnt_nxt = settle_cnt - 1'b1;
                end else if (bit_idx != '0) begin
                    // Keep/clear this bit, then try the next lower one.
                    code[idx_m1]   = 1'b1;
                    bit_idx_nxt    = idx_m1;
                    trial_nxt      = code;
                    dac_code_nxt   = code;
                    settle_cnt_nxt = SETTLE_W'(SETTLE_CYCLES - 1);
                end else begin
                    state_nxt    = IDLE;
                    data_nxt     = code;
                    valid_nxt    = 1'b1;
                    busy_nxt     = 1'b0;
                    dac_code_nxt = '0;
                    trial_nxt    = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.sample_o   = sample;
    assign bus.dac_code_o = dac_code;
    assign bus.busy_o     = busy;
    assign bus.data_o     = data;
    assign bus.valid_o    = valid;
endmodule
